uart_tx_frame: RTL and testbench

//  Serial transmitter for the UART link. It takes a parallel byte, frames it as

---
 rtl/uart_tx_frame.sv | 141 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity and stop bit(s),
// each held for BIT_PERIOD clocks. All outputs are registered.
module uart_tx_frame #(
    parameter int BIT_PERIOD = 10,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cyc, cyc_n;
    logic [2:0]           bit_idx, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par, par_n;
    logic                 so_n, busy_n, done_n;
    logic                 bit_end;

    assign bit_end = (cyc == CW'(BIT_PERIOD - 1));

    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        bit_n   = bit_idx;
        shift_n = shift;
        par_n   = par;
        done_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx_start) begin
                    state_n = S_START;
                    cyc_n   = '0;
                    bit_n   = '0;
                    shift_n = tx_data;
                    par_n   = (^tx_data) ^ (PARITY == 2);
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    cyc_n   = '0;
                    bit_n   = '0;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cyc_n   = '0;
                    shift_n = shift >> 1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    cyc_n   = '0;
                    bit_n   = '0;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cyc_n = '0;
                    if (bit_idx == 3'(STOP_BITS - 1)) begin
                        state_n = S_IDLE;
                        bit_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cyc_n   = '0;
                bit_n   = '0;
            end
        endcase

        // Line level is derived from the next state so serial_out stays a pure register.
        case (state_n)
            S_START:  so_n = 1'b0;
            S_DATA:   so_n = shift_n[0];
            S_PARITY: so_n = par_n;
            default:  so_n = 1'b1;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            cyc        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par        <= 1'b0;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_n;
            cyc        <= cyc_n;
            bit_idx    <= bit_n;
            shift      <= shift_n;
            par        <= par_n;
            serial_out <= so_n;
            tx_busy    <= busy_n;
            tx_done    <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench: three framer configurations share one stimulus stream and are
// compared every cycle against a per-cycle expected-output queue built from the frame rules.
module tb_uart_tx_frame;

    localparam int BP[3]  = '{10, 10, 3};
    localparam int DB[3]  = '{8, 8, 6};
    localparam int PAR[3] = '{0, 1, 2};
    localparam int SB[3]  = '{1, 1, 2};

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       so[3];
    logic       busy[3];
    logic       done[3];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.BIT_PERIOD(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
        .serial_out(so[0]), .tx_busy(busy[0]), .tx_done(done[0]));

    uart_tx_frame #(.BIT_PERIOD(10), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_b (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
        .serial_out(so[1]), .tx_busy(busy[1]), .tx_done(done[1]));

    uart_tx_frame #(.BIT_PERIOD(3), .DATA_BITS(6), .PARITY(2), .STOP_BITS(2)) u_c (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data[5:0]),
        .serial_out(so[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    // Expected {serial_out, tx_busy, tx_done} for each upcoming cycle; empty means idle.
    logic [2:0] q[3][$];
    logic [2:0] exp_v[3];

    function automatic logic frame_bit(input int inst, input int idx, input logic [7:0] d);
        logic x;
        if (idx == 0) return 1'b0;
        if (idx <= DB[inst]) return d[idx-1];
        if (PAR[inst] != 0 && idx == DB[inst] + 1) begin
            x = 1'b0;
            for (int j = 0; j < DB[inst]; j++) x = x ^ d[j];
            return (PAR[inst] == 2) ? ~x : x;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        for (int i = 0; i < 3; i++) begin
            if (!n_rst) begin
                q[i].delete();
                exp_v[i] <= 3'b100;
            end else begin
                if (q[i].size() == 0 && tx_start) begin
                    for (int b = 0; b < 1 + DB[i] + (PAR[i] != 0 ? 1 : 0) + SB[i]; b++)
                        for (int c = 0; c < BP[i]; c++)
                            q[i].push_back({frame_bit(i, b, tx_data), 2'b10});
                    q[i].push_back(3'b101);
                end
                exp_v[i] <= (q[i].size() != 0) ? q[i].pop_front() : 3'b100;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("outputs_inst%0d", i), {29'd0, so[i], busy[i], done[i]}, {29'd0, exp_v[i]});
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    logic [9:0] pat_a5;
    int         done_a, done_b, done_cnt;

    initial begin
        pat_a5 = 10'b1101001010;

        // 1: reset, then idle
        #2 n_rst = 1'b0;
        #1 chk("reset_serial", {31'd0, so[0]}, 1);
        chk("reset_busy", {31'd0, busy[0]}, 0);
        chk("reset_done", {31'd0, done[0]}, 0);
        tick();
        tick();
        n_rst = 1'b1;
        for (int n = 0; n < 20; n++) tick();
        chk("idle_line", {29'd0, so[0], busy[0], done[0]}, 3'b100);

        // 2 and 3: one frame, seen by the plain and even-parity instances
        send(8'hA5);
        tx_data = 8'h07;
        done_a = -1;
        done_b = -1;
        for (int n = 1; n < 130; n++) begin
            tick();
            if (n % 10 == 5 && n < 100) chk("a5_bit", {31'd0, so[0]}, {31'd0, pat_a5[n/10]});
            if (done[0] && done_a < 0) done_a = n;
            if (done[1] && done_b < 0) done_b = n;
        end
        chk("a5_done_latency", done_a, 100);
        chk("a5_b_done_latency", done_b, 110);

        send(8'h07);
        for (int n = 1; n < 120; n++) begin
            tick();
            if (n == 95) chk("parity_07", {31'd0, so[1]}, 1);
            if (n == 105) chk("stop_bit_b", {31'd0, so[1]}, 1);
            if (n == 110) chk("done_b_110", {31'd0, done[1]}, 1);
        end

        // 4: re-pulse during a frame is ignored
        send(8'h3C);
        done_cnt = 0;
        for (int n = 1; n < 130; n++) begin
            if (n == 41) begin
                tx_data  = 8'hFF;
                tx_start = 1'b1;
            end
            tick();
            tx_start = 1'b0;
            if (n == 55) chk("ignored_restart_bit4", {31'd0, so[0]}, 1);
            if (n == 75) chk("ignored_restart_bit6", {31'd0, so[0]}, 0);
            if (done[0]) done_cnt++;
        end
        chk("single_done", done_cnt, 1);

        // 5: tx_start held across tx_done
        send(8'h55);
        tx_start = 1'b1;
        tx_data  = 8'hAA;
        for (int n = 1; n <= 100; n++) tick();
        chk("b2b_done", {31'd0, done[0]}, 1);
        tick();
        tx_start = 1'b0;
        chk("b2b_start_bit", {30'd0, so[0], busy[0]}, 2'b01);
        for (int n = 0; n < 115; n++) tick();

        // 6: async reset during data bit 4
        send(8'h00);
        for (int n = 1; n <= 53; n++) tick();
        #2 n_rst = 1'b0;
        #1 chk("abort_serial", {31'd0, so[0]}, 1);
        chk("abort_busy", {31'd0, busy[0]}, 0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        send(8'h81);
        done_a = -1;
        for (int n = 1; n < 120; n++) begin
            tick();
            if (done[0] && done_a < 0) done_a = n;
        end
        chk("post_reset_frame", done_a, 100);

        // random traffic
        for (int n = 0; n < 2500; n++) begin
            tx_start = ($urandom_range(0, 5) == 0);
            tx_data  = 8'($urandom);
            tick();
        end
        tx_start = 1'b0;
        for (int n = 0; n < 120; n++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
